lbm_equilibrium_init: RTL

- Inverse of the collider's moment step: takes per-cell macroscopic values (rho, u_x, u_y) and emits the nine D2Q9 equilibrium distributions f_eq_i = rho * w_i * poly_i(u).
- Sits in front of the lattice memory and writes the initial state, or boundary/inlet cells, before collision and streaming start.
- Walks an NX x NY grid: one cell per accepted input beat, with a 3-stage pipeline and valid/ready backpressure.

---
 rtl/lbm_pkg.sv | 31 +++
 rtl/lbm_qmul.sv | 16 +
 rtl/lbm_equilibrium_init.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/lbm_pkg.sv
// Shared definitions for the D2Q9 equilibrium initialiser: Q3.13 format,
// lattice weights, polynomial constants and the output direction order.
package lbm_pkg;

    localparam int W    = 16;
    localparam int FRAC = 13;
    localparam int NDIR = 9;

    localparam logic signed [W-1:0] W_NULL        = 16'sh0E39;  // 4/9
    localparam logic signed [W-1:0] W_SIDE        = 16'sh038E;  // 1/9
    localparam logic signed [W-1:0] W_DIAG        = 16'sh00E4;  // 1/36
    localparam logic signed [W-1:0] ONE           = 16'sh2000;
    localparam logic signed [W-1:0] THREE         = 16'sh6000;
    localparam logic signed [W-1:0] THREE_HALVES  = 16'sh3000;
    localparam logic signed [W-1:0] NINE_QUARTERS = 16'sh4800;

    // Output ordering; side directions sit on odd indices, diagonals on even.
    typedef enum logic [3:0] {
        DIR_NULL = 4'd0, DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } d2q9_dir_e;

    function automatic logic signed [W-1:0] dir_weight(input int dir);
        if (dir == 0)
            return W_NULL;
        else if (dir % 2 == 1)
            return W_SIDE;
        else
            return W_DIAG;
    endfunction

endpackage

// File: rtl/lbm_qmul.sv
// Q3.13 signed multiply: full 32-bit product, arithmetic shift right by FRAC,
// keep the low W bits. No rounding, no saturation; overflow wraps.
module lbm_qmul
    import lbm_pkg::*;
(
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y
);

    logic signed [2*W-1:0] prod;

    assign prod = a * b;
    assign y    = W'(prod >>> FRAC);

endmodule

// File: rtl/lbm_equilibrium_init.sv
// D2Q9 equilibrium generator: (rho, u_x, u_y) per cell -> nine f_eq values.
// Walks an NX x NY frame, 3-stage pipeline, valid/ready with global stall.
module lbm_equilibrium_init
    import lbm_pkg::*;
#(
    parameter  int NX = 64,
    parameter  int NY = 32,
    localparam int XW = (NX > 1) ? $clog2(NX) : 1,
    localparam int YW = (NY > 1) ? $clog2(NY) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] rho,
    input  logic signed [W-1:0] u_x,
    input  logic signed [W-1:0] u_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] f_null,
    output logic signed [W-1:0] f_n,
    output logic signed [W-1:0] f_ne,
    output logic signed [W-1:0] f_e,
    output logic signed [W-1:0] f_se,
    output logic signed [W-1:0] f_s,
    output logic signed [W-1:0] f_sw,
    output logic signed [W-1:0] f_w,
    output logic signed [W-1:0] f_nw,
    output logic [XW-1:0]       cell_x,
    output logic [YW-1:0]       cell_y,
    output logic                last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XW-1:0] X_MAX = XW'(NX - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(NY - 1);

    logic [1:0]    state;
    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;
    logic          stall, accept, at_last_cell, drain_empty_next;
    logic          s1_valid, s2_valid, s3_valid;

    // Square/linear operand indices: 0 = u_x, 1 = u_y, 2 = u_x+u_y, 3 = u_x-u_y.
    logic signed [W-1:0] sq_in  [4];
    logic signed [W-1:0] sq_c   [4];
    logic signed [W-1:0] lin_c  [4];
    logic signed [W-1:0] s1_sq  [4];
    logic signed [W-1:0] s1_lin [4];
    logic signed [W-1:0] s1_rho;
    logic [XW-1:0]       s1_x;
    logic [YW-1:0]       s1_y;
    logic                s1_last;

    logic signed [W-1:0] sum_sq, usq_c;
    logic signed [W-1:0] half_c  [4];
    logic signed [W-1:0] poly_c  [NDIR];
    logic signed [W-1:0] s2_poly [NDIR];
    logic signed [W-1:0] s2_rho;
    logic [XW-1:0]       s2_x;
    logic [YW-1:0]       s2_y;
    logic                s2_last;

    logic signed [W-1:0] t_c [NDIR];
    logic signed [W-1:0] f_c [NDIR];
    logic signed [W-1:0] f_q [NDIR];

    assign stall            = s3_valid && !out_ready;
    assign in_ready         = (state == S_RUN) && !stall;
    assign accept           = in_valid && in_ready;
    assign at_last_cell     = (cnt_x == X_MAX) && (cnt_y == Y_MAX);
    // Pipeline is empty next cycle when nothing is upstream and the output either is empty or leaves now.
    assign drain_empty_next = !s1_valid && !s2_valid && !stall;
    assign busy             = (state != S_IDLE);
    assign done             = (state == S_DONE);
    assign out_valid        = s3_valid;

    // Frame FSM and cell counters.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt_x <= '0;
            cnt_y <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_RUN;
                    cnt_x <= '0;
                    cnt_y <= '0;
                end
                S_RUN: if (accept) begin
                    if (cnt_x == X_MAX) begin
                        cnt_x <= '0;
                        cnt_y <= (cnt_y == Y_MAX) ? '0 : cnt_y + 1'b1;
                        if (at_last_cell)
                            state <= S_DRAIN;
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                S_DRAIN: if (drain_empty_next) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Pipeline valid bits: a stall freezes all stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Stage 1 operands: the raw velocities, their sum and difference.
    // NOTE: every element is assigned on every pass, so no latch can be inferred.
    always_comb begin
        sq_in[0] = u_x;
        sq_in[1] = u_y;
        sq_in[2] = u_x + u_y;
        sq_in[3] = u_x - u_y;
    end

    for (genvar k = 0; k < 4; k++) begin : g_stage1
        lbm_qmul u_sq  (.a(sq_in[k]), .b(sq_in[k]), .y(sq_c[k]));
        lbm_qmul u_lin (.a(THREE),    .b(sq_in[k]), .y(lin_c[k]));
    end

    assign sum_sq = s1_sq[0] + s1_sq[1];
    lbm_qmul u_usq (.a(THREE_HALVES), .b(sum_sq), .y(usq_c));

    for (genvar k = 0; k < 4; k++) begin : g_stage2
        lbm_qmul u_half (.a(NINE_QUARTERS), .b(s1_sq[k] <<< 1), .y(half_c[k]));
    end

    // Stage 2 polynomials: one + c.u*3 + 9/2 (c.u)^2 - 3/2 |u|^2 per direction.
    always_comb begin
        poly_c[DIR_NULL] = ONE - usq_c;
        poly_c[DIR_E]    = ONE + s1_lin[0] + half_c[0] - usq_c;
        poly_c[DIR_W]    = ONE - s1_lin[0] + half_c[0] - usq_c;
        poly_c[DIR_N]    = ONE + s1_lin[1] + half_c[1] - usq_c;
        poly_c[DIR_S]    = ONE - s1_lin[1] + half_c[1] - usq_c;
        poly_c[DIR_NE]   = ONE + s1_lin[2] + half_c[2] - usq_c;
        poly_c[DIR_SW]   = ONE - s1_lin[2] + half_c[2] - usq_c;
        poly_c[DIR_SE]   = ONE + s1_lin[3] + half_c[3] - usq_c;
        poly_c[DIR_NW]   = ONE - s1_lin[3] + half_c[3] - usq_c;
    end

    for (genvar i = 0; i < NDIR; i++) begin : g_stage3
        lbm_qmul u_t (.a(dir_weight(i)), .b(s2_poly[i]), .y(t_c[i]));
        lbm_qmul u_f (.a(s2_rho),        .b(t_c[i]),     .y(f_c[i]));
    end

    // Stage 1/2 data registers, qualified by the valid bits alongside.
    // NOTE: datapath registers carry no reset; the valid bits alone decide what is meaningful.
    always_ff @(posedge clk) begin
        if (!stall) begin
            s1_sq   <= sq_c;
            s1_lin  <= lin_c;
            s1_rho  <= rho;
            s1_x    <= cnt_x;
            s1_y    <= cnt_y;
            s1_last <= at_last_cell;
            s2_poly <= poly_c;
            s2_rho  <= s1_rho;
            s2_x    <= s1_x;
            s2_y    <= s1_y;
            s2_last <= s1_last;
        end
    end

    // Output register: cleared on reset, held while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIR; i++) f_q[i] <= '0;
            cell_x <= '0;
            cell_y <= '0;
            last   <= 1'b0;
        end else if (!stall) begin
            f_q    <= f_c;
            cell_x <= s2_x;
            cell_y <= s2_y;
            last   <= s2_last;
        end
    end

    assign f_null = f_q[DIR_NULL];
    assign f_n    = f_q[DIR_N];
    assign f_ne   = f_q[DIR_NE];
    assign f_e    = f_q[DIR_E];
    assign f_se   = f_q[DIR_SE];
    assign f_s    = f_q[DIR_S];
    assign f_sw   = f_q[DIR_SW];
    assign f_w    = f_q[DIR_W];
    assign f_nw   = f_q[DIR_NW];

endmodule
